// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: mode encoding, control tokens, guard bands, TERC4 table and decode helpers.
package tmds_pkg;

  typedef enum logic [2:0] {
    MODE_CTRL   = 3'd0,
    MODE_VIDEO  = 3'd1,
    MODE_VGUARD = 3'd2,
    MODE_ISLAND = 3'd3,
    MODE_IGUARD = 3'd4
  } mode_t;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  localparam logic [9:0] VIDEO_GUARD_CH0   = 10'b1011001100;
  localparam logic [9:0] VIDEO_GUARD_CH1   = 10'b0100110011;
  localparam logic [9:0] VIDEO_GUARD_CH2   = 10'b1011001100;
  localparam logic [9:0] ISLAND_GUARD_CH12 = 10'b0100110011;

  localparam int LEAD_WORDS = 2;

  localparam logic [9:0] TERC4_TABLE [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  function automatic logic is_ctrl_token(input logic [9:0] w);
    return (w == CTRL_TOKEN_00) || (w == CTRL_TOKEN_01) ||
           (w == CTRL_TOKEN_10) || (w == CTRL_TOKEN_11);
  endfunction

  function automatic logic [1:0] ctrl_decode(input logic [9:0] w);
    logic [1:0] c;
    case (w)
      CTRL_TOKEN_01: c = 2'b01;
      CTRL_TOKEN_10: c = 2'b10;
      CTRL_TOKEN_11: c = 2'b11;
      default:       c = 2'b00;
    endcase
    return c;
  endfunction

  // Returns {hit, nibble}.
  function automatic logic [4:0] terc4_decode(input logic [9:0] w);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (w == TERC4_TABLE[i]) r = {1'b1, i[3:0]};
    end
    return r;
  endfunction

  function automatic logic [7:0] video_decode(input logic [9:0] w);
    logic [7:0] q;
    logic [7:0] d;
    q = w[9] ? ~w[7:0] : w[7:0];
    d = 8'd0;
    d[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

endpackage

// File: rtl/tmds_word_aligner.sv
// Word aligner: stage 0/1 rotation of the raw word and the SEARCH/CONFIRM/LOCKED hunt for control tokens.
// TMDS_DEC_LOSS_CNT_EN adds a saturating count of lock losses.
module tmds_word_aligner
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT   = 8,
  parameter int SEARCH_DWELL = 64,
  parameter int MAX_GAP      = 4096
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic [9:0] tmds_in,
  output logic [9:0] aligned,
  output logic       is_ctrl,
  output logic       tmds_locked,
`ifdef TMDS_DEC_LOSS_CNT_EN
  output logic [7:0] lock_loss_count,
  output logic [3:0] bit_offset
`else
  output logic [3:0] bit_offset
`endif
);

  localparam logic [1:0] A_SEARCH  = 2'd0;
  localparam logic [1:0] A_CONFIRM = 2'd1;
  localparam logic [1:0] A_LOCKED  = 2'd2;

  localparam int DW = $clog2(SEARCH_DWELL + 1);
  localparam int GW = $clog2(MAX_GAP + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SEARCH_DWELL - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(MAX_GAP - 1);
  localparam logic [3:0]    CNT_LAST   = 4'(LOCK_COUNT - 1);

  logic [1:0]    state;
  logic [9:0]    prev;
  logic [19:0]   window;
  logic [DW-1:0] dwell;
  logic [GW-1:0] gap;
  logic [3:0]    cnt;
  logic [3:0]    next_offset;
  logic          lock_drop;

  assign window      = {tmds_in, prev};
  assign next_offset = (bit_offset == 4'd9) ? 4'd0 : bit_offset + 4'd1;
  assign is_ctrl     = is_ctrl_token(aligned);
  assign tmds_locked = (state == A_LOCKED);
  assign lock_drop   = (state == A_LOCKED) && !is_ctrl && (gap == GAP_LAST);

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      prev       <= '0;
      aligned    <= '0;
      state      <= A_SEARCH;
      bit_offset <= '0;
      dwell      <= '0;
      gap        <= '0;
      cnt        <= '0;
    end else begin
      prev    <= tmds_in;
      aligned <= window[{1'b0, bit_offset} +: 10];
      case (state)
        A_SEARCH: begin
          if (is_ctrl) begin
            state <= A_CONFIRM;
            cnt   <= 4'd1;
            dwell <= '0;
          end else if (dwell == DWELL_LAST) begin
            dwell      <= '0;
            bit_offset <= next_offset;
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        A_CONFIRM: begin
          if (is_ctrl) begin
            cnt <= cnt + 4'd1;
            if (cnt == CNT_LAST) begin
              state <= A_LOCKED;
              gap   <= '0;
            end
          end else begin
            // A broken run restarts the hunt at the same rotation.
            state <= A_SEARCH;
            cnt   <= '0;
            dwell <= '0;
          end
        end
        A_LOCKED: begin
          if (is_ctrl) begin
            gap <= '0;
          end else if (lock_drop) begin
            state      <= A_SEARCH;
            bit_offset <= next_offset;
            gap        <= '0;
            cnt        <= '0;
            dwell      <= '0;
          end else begin
            gap <= gap + 1'b1;
          end
        end
        default: state <= A_SEARCH;
      endcase
    end
  end

`ifdef TMDS_DEC_LOSS_CNT_EN
  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      lock_loss_count <= '0;
    end else if (lock_drop && (lock_loss_count != 8'hFF)) begin
      lock_loss_count <= lock_loss_count + 8'd1;
    end
  end
`endif

endmodule

// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder: aligns raw words, classifies each symbol period and recovers the payload (2-cycle latency).
// TMDS_DEC_LOSS_CNT_EN exposes lock_loss_count.
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int CN           = 0,
  parameter int LOCK_COUNT   = 8,
  parameter int SEARCH_DWELL = 64,
  parameter int MAX_GAP      = 4096
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic [9:0] tmds_in,
  input  logic       island_hint,
  output logic       tmds_locked,
  output logic [3:0] bit_offset,
  output logic [2:0] mode,
  output logic [7:0] video_data,
  output logic [3:0] data_island_data,
`ifdef TMDS_DEC_LOSS_CNT_EN
  output logic [7:0] lock_loss_count,
  output logic [1:0] control_data
`else
  output logic [1:0] control_data
`endif
);

  localparam logic [1:0] P_CTRL   = 2'd0;
  localparam logic [1:0] P_LEAD   = 2'd1;
  localparam logic [1:0] P_VIDEO  = 2'd2;
  localparam logic [1:0] P_ISLAND = 2'd3;
  localparam logic       GCNT_LAST = 1'(LEAD_WORDS - 2);

  logic [9:0] aligned;
  logic       is_ctrl;
  logic [1:0] pstate;
  logic       gcnt;
  logic       hint_q;
  logic [4:0] terc4;

  tmds_word_aligner #(
    .LOCK_COUNT  (LOCK_COUNT),
    .SEARCH_DWELL(SEARCH_DWELL),
    .MAX_GAP     (MAX_GAP)
  ) u_aligner (
    .clk_pixel      (clk_pixel),
    .reset_n        (reset_n),
    .tmds_in        (tmds_in),
    .aligned        (aligned),
    .is_ctrl        (is_ctrl),
    .tmds_locked    (tmds_locked),
`ifdef TMDS_DEC_LOSS_CNT_EN
    .lock_loss_count(lock_loss_count),
    .bit_offset     (bit_offset)
`else
    .bit_offset     (bit_offset)
`endif
  );

  assign terc4 = terc4_decode(aligned);

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      pstate           <= P_CTRL;
      gcnt             <= 1'b0;
      hint_q           <= 1'b0;
      mode             <= MODE_CTRL;
      video_data       <= '0;
      data_island_data <= '0;
      control_data     <= '0;
    end else if (!tmds_locked) begin
      pstate <= P_CTRL;
      gcnt   <= 1'b0;
      mode   <= MODE_CTRL;
    end else if (is_ctrl) begin
      // A control token ends any period, including an aborted leading guard.
      pstate       <= P_CTRL;
      mode         <= MODE_CTRL;
      control_data <= ctrl_decode(aligned);
    end else begin
      case (pstate)
        P_CTRL: begin
          pstate <= P_LEAD;
          gcnt   <= 1'b0;
          hint_q <= island_hint;
          mode   <= island_hint ? MODE_IGUARD : MODE_VGUARD;
        end
        P_LEAD: begin
          mode <= hint_q ? MODE_IGUARD : MODE_VGUARD;
          if (gcnt == GCNT_LAST) pstate <= hint_q ? P_ISLAND : P_VIDEO;
          else gcnt <= gcnt + 1'b1;
        end
        P_VIDEO: begin
          mode       <= MODE_VIDEO;
          video_data <= video_decode(aligned);
        end
        default: begin
          // Channel 0 trailing guard is itself a TERC4 code and decodes as data.
          if ((CN != 0) && (aligned == ISLAND_GUARD_CH12)) begin
            mode <= MODE_IGUARD;
          end else begin
            mode             <= MODE_ISLAND;
            data_island_data <= terc4[4] ? terc4[3:0] : 4'd0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder (CN=1, MAX_GAP=16): table-driven decode vectors plus lock/reset sequences.
module tb_tmds_channel_decoder;

  logic       clk_pixel = 1'b0;
  logic       reset_n;
  logic [9:0] tmds_in;
  logic       island_hint;
  logic       tmds_locked;
  logic [3:0] bit_offset;
  logic [2:0] mode;
  logic [7:0] video_data;
  logic [3:0] data_island_data;
  logic [1:0] control_data;
`ifdef TMDS_DEC_LOSS_CNT_EN
  logic [7:0] lock_loss_count;
`endif

  always #5 clk_pixel = ~clk_pixel;

  tmds_channel_decoder #(
    .CN          (1),
    .LOCK_COUNT  (8),
    .SEARCH_DWELL(64),
    .MAX_GAP     (16)
  ) dut (
    .clk_pixel       (clk_pixel),
    .reset_n         (reset_n),
    .tmds_in         (tmds_in),
    .island_hint     (island_hint),
    .tmds_locked     (tmds_locked),
    .bit_offset      (bit_offset),
    .mode            (mode),
    .video_data      (video_data),
    .data_island_data(data_island_data),
`ifdef TMDS_DEC_LOSS_CNT_EN
    .lock_loss_count (lock_loss_count),
    .control_data    (control_data)
`else
    .control_data    (control_data)
`endif
  );

  typedef struct {
    logic [9:0] word;
    logic       hint;
    logic [2:0] mode;
    logic [7:0] vid;
    logic [3:0] isl;
    logic [1:0] ctl;
  } vec_t;

  localparam int NV = 22;
  localparam logic [9:0] T00  = 10'b1101010100;
  localparam logic [9:0] FILL = 10'b0100000000;

  vec_t       vecs [NV];
  int         checks = 0;
  int         fails = 0;
  int         tb_off = 0;
  logic [9:0] last_w = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Serialises words into a bit stream whose word boundary sits tb_off bits into each deserialised word.
  task automatic send(input logic [9:0] w);
    logic [19:0] pair;
    pair    = {w, last_w};
    tmds_in = 10'(pair >> (10 - tb_off));
    last_w  = w;
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " locked"}, 32'(tmds_locked), 0);
    check({tag, " offset"}, 32'(bit_offset), 0);
    check({tag, " mode"}, 32'(mode), 0);
    check({tag, " video"}, 32'(video_data), 0);
    check({tag, " island"}, 32'(data_island_data), 0);
    check({tag, " control"}, 32'(control_data), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          word           hint  mode  vid    isl   ctl
    vecs[0]  = '{10'b1101010100, 1'b0, 3'd0, 8'h00, 4'h0, 2'b00};
    vecs[1]  = '{10'b1011001100, 1'b0, 3'd2, 8'h00, 4'h0, 2'b00};
    vecs[2]  = '{10'b1011001100, 1'b0, 3'd2, 8'h00, 4'h0, 2'b00};
    vecs[3]  = '{10'b0100000000, 1'b0, 3'd1, 8'h00, 4'h0, 2'b00};
    vecs[4]  = '{10'b1000000000, 1'b0, 3'd1, 8'hFF, 4'h0, 2'b00};
    vecs[5]  = '{10'b0000001111, 1'b0, 3'd1, 8'hEF, 4'h0, 2'b00};
    vecs[6]  = '{10'b1100001111, 1'b0, 3'd1, 8'h10, 4'h0, 2'b00};
    vecs[7]  = '{10'b0101010100, 1'b0, 3'd0, 8'h10, 4'h0, 2'b10};
    vecs[8]  = '{10'b0100110011, 1'b1, 3'd4, 8'h10, 4'h0, 2'b10};
    vecs[9]  = '{10'b0100110011, 1'b1, 3'd4, 8'h10, 4'h0, 2'b10};
    vecs[10] = '{10'b1010011100, 1'b1, 3'd3, 8'h10, 4'h0, 2'b10};
    vecs[11] = '{10'b0101100011, 1'b1, 3'd3, 8'h10, 4'hE, 2'b10};
    vecs[12] = '{10'b1011100100, 1'b1, 3'd3, 8'h10, 4'h2, 2'b10};
    vecs[13] = '{10'b1111111111, 1'b1, 3'd3, 8'h10, 4'h0, 2'b10};
    vecs[14] = '{10'b0100110011, 1'b1, 3'd4, 8'h10, 4'h0, 2'b10};
    vecs[15] = '{10'b0100110011, 1'b1, 3'd4, 8'h10, 4'h0, 2'b10};
    vecs[16] = '{10'b0010101011, 1'b1, 3'd0, 8'h10, 4'h0, 2'b01};
    vecs[17] = '{10'b1010101011, 1'b0, 3'd0, 8'h10, 4'h0, 2'b11};
    vecs[18] = '{10'b1101010100, 1'b0, 3'd0, 8'h10, 4'h0, 2'b00};
    vecs[19] = '{10'b1011001100, 1'b0, 3'd2, 8'h10, 4'h0, 2'b00};
    vecs[20] = '{10'b0101010100, 1'b0, 3'd0, 8'h10, 4'h0, 2'b10};
    vecs[21] = '{10'b1101010100, 1'b0, 3'd0, 8'h10, 4'h0, 2'b00};

    reset_n     = 1'b0;
    island_hint = 1'b0;
    tmds_in     = '0;
    @(posedge clk_pixel);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;

    // Lock acquisition on a stream rotated by 3 bits.
    tb_off = 3;
    repeat (600) send(T00);
    check("acq offset", 32'(bit_offset), 3);
    check("acq locked", 32'(tmds_locked), 1);
    check("acq mode", 32'(mode), 0);
    check("acq control", 32'(control_data), 0);

    // Decode table: word i reaches the outputs two edges after it is sampled.
    for (int i = 0; i < NV + 2; i++) begin
      if (i >= 2) island_hint = vecs[i-2].hint;
      send((i < NV) ? vecs[i].word : T00);
      if (i >= 2) begin
        check($sformatf("vec%0d mode", i - 2), 32'(mode), 32'(vecs[i-2].mode));
        check($sformatf("vec%0d video", i - 2), 32'(video_data), 32'(vecs[i-2].vid));
        check($sformatf("vec%0d island", i - 2), 32'(data_island_data), 32'(vecs[i-2].isl));
        check($sformatf("vec%0d control", i - 2), 32'(control_data), 32'(vecs[i-2].ctl));
      end
    end

    // Reset while inside a video period.
    island_hint = 1'b0;
    send(T00);
    send(10'b1011001100);
    send(10'b1011001100);
    repeat (3) send(FILL);
    check("pre-reset mode", 32'(mode), 1);
    reset_n = 1'b0;
    @(posedge clk_pixel);
    #1;
    check_all_zero("midreset");
    reset_n = 1'b1;

    // CONFIRM broken by a video word must restart the token count.
    tb_off = 0;
    repeat (5) send(T00);
    send(FILL);
    repeat (8) send(T00);
    send(FILL);
    check("confirm 7 tokens locked", 32'(tmds_locked), 0);
    send(FILL);
    check("confirm 8 tokens locked", 32'(tmds_locked), 1);
    check("confirm offset", 32'(bit_offset), 0);

    // Lock loss after MAX_GAP non-control words.
    repeat (3) send(T00);
    repeat (17) send(FILL);
    check("gap 15 locked", 32'(tmds_locked), 1);
    send(FILL);
    check("gap 16 locked", 32'(tmds_locked), 0);
    check("gap 16 offset", 32'(bit_offset), 1);
`ifdef TMDS_DEC_LOSS_CNT_EN
    check("loss count", 32'(lock_loss_count), 1);
`endif
    send(FILL);
    check("unlocked mode", 32'(mode), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
